cfu_req_initiator: RTL and testbench
====================================

// Module: cfu_req_initiator
// PURPOSE
//  CPU-side initiator of the CFU request/response protocol. Accepts custom-instruction issues from the
//  execute stage, drives req_valid/req_ready transfers (function id + two operands) to an attached
//  CFU, matches in-order responses to issue tags and returns them on a writeback port.
//  Sits between the CVA5 custom-instruction unit and any L2 (handshaked) CFU.
// PARAMETERS
//  FUNC_ID_W        10   width of CFU function id
//  DATA_W           32   operand / result width
//  TAG_W            3    writeback tag (rd/instruction id) width
//  MAX_OUTSTANDING  4    max requests sent and not yet answered (power of 2, >=2)
//  TIMEOUT_CYCLES   1024 cycles head request may wait for a response before timeout (0 = disabled)
// PORTS
//  clk                  in   1          clock
//  rst                  in   1          synchronous active-high reset
//  issue_valid          in   1          execute stage presents a custom instruction
//  issue_ready          out  1          instruction accepted this cycle when valid&ready
//  issue_func_id        in   FUNC_ID_W  CFU function id
//  issue_rs1            in   DATA_W     operand 0
//  issue_rs2            in   DATA_W     operand 1
//  issue_tag            in   TAG_W      writeback tag
//  cfu_req_valid        out  1          request to CFU valid
//  cfu_req_ready        in   1          CFU accepts request
//  cfu_req_function_id  out  FUNC_ID_W  function id to CFU
//  cfu_req_data0        out  DATA_W     operand 0 to CFU
//  cfu_req_data1        out  DATA_W     operand 1 to CFU
//  cfu_resp_valid       in   1          CFU response valid
//  cfu_resp_ready       out  1          initiator accepts response
//  cfu_resp_data        in   DATA_W     CFU result
//  cfu_resp_status      in   1          1 = CFU reports error
//  wb_valid             out  1          result available
//  wb_ready             in   1          writeback accepts result
//  wb_tag               out  TAG_W      tag of returned result
//  wb_data              out  DATA_W     result
//  wb_err               out  1          CFU error status for this result
//  timeout_err          out  1          sticky: head request exceeded TIMEOUT_CYCLES
// BEHAVIOUR
//  - Reset: cfu_req_valid=0, wb_valid=0, wb_err=0, timeout_err=0, tag FIFO empty, timeout counter 0;
//    data outputs 0. Reset mid-transaction drops all in-flight state; late CFU responses after reset are
//    accepted (cfu_resp_ready=1) and discarded while FIFO empty.
//  - Request stage: one register. issue_ready = !timeout_err & !fifo_full & (!cfu_req_valid | cfu_req_ready).
//    On issue fire: load func/rs1/rs2, set cfu_req_valid next cycle, push issue_tag into tag FIFO same edge.
//    Issue->cfu_req_valid latency 1 cycle. Full throughput (1/cycle) when CFU ready and FIFO not full.
//  - cfu_req_* outputs stable while cfu_req_valid & !cfu_req_ready. Valid drops after fire with no new issue.
//  - Tag FIFO: depth MAX_OUTSTANDING, counts issued-not-answered. Push on issue fire, pop on response fire;
//    simultaneous push+pop keeps count; push when full impossible (issue_ready low).
//  - Response: responses in order. cfu_resp_ready = (!wb_valid | wb_ready) | fifo_empty.
//    Fire with FIFO non-empty: register wb_data=cfu_resp_data, wb_err=cfu_resp_status, wb_tag=FIFO head,
//    wb_valid=1 next cycle (latency 1). Fire with FIFO empty: discarded, no wb.
//  - Writeback: wb_* held stable while wb_valid & !wb_ready; back-to-back results at 1/cycle when wb_ready=1.
//  - Timeout: counter clears on any response fire or when FIFO empty; else increments each cycle FIFO
//    non-empty. Reaching TIMEOUT_CYCLES sets timeout_err (sticky until rst); issue_ready forced 0;
//    outstanding responses still drain normally. TIMEOUT_CYCLES=0: counter/flag tied to 0.
//  - Counter width $clog2(TIMEOUT_CYCLES+1), saturates; FIFO pointers wrap modulo MAX_OUTSTANDING.
// STRUCTURE
//  - Package cfu_pkg: FUNC_ID_W/DATA_W defaults, typedef cfu_req_t {function_id,data0,data1},
//    typedef cfu_resp_t {data,status}; shared with CFU responders.
//  - Sub-module cfu_tag_fifo (sync FIFO, count, full/empty); rest inline.
// TESTING
//  - Single op: issue func=0,rs1=0x5,rs2=0x7,tag=3; CFU model adds, ready=1 -> req next cycle, wb tag=3 data=0xC err=0.
//  - Backpressure: cfu_req_ready=0 for 5 cycles -> req fields stable, issue_ready=0 after 1 queued, no loss.
//  - Fill: 4 issues, CFU withholds responses -> issue_ready=0 on 5th; release -> wb tags 0,1,2,3 in order.
//  - wb_ready=0 3 cycles with 2 responses pending -> cfu_resp_ready=0, wb held, then both delivered in order.
//  - Error: cfu_resp_status=1 on tag 6 -> wb_err=1 only for tag 6.
//  - Timeout (TIMEOUT_CYCLES=16): no response -> timeout_err=1 at cycle 16, issue_ready=0; rst clears it.

Source files
------------

// File: rtl/cfu_pkg.sv
// Shared definitions for the CFU request/response protocol.
// Used by the CPU-side initiator (cfu_req_initiator) and by CFU responders.
//   CFU_FUNC_ID_W / CFU_DATA_W / CFU_TAG_W : default field widths
//   cfu_req_t  : one request beat  {function_id, data0, data1}
//   cfu_resp_t : one response beat {data, status}
//   timeout_cnt_w() : width of a saturating cycle counter able to hold 0..limit
package cfu_pkg;

  localparam int CFU_FUNC_ID_W = 10;
  localparam int CFU_DATA_W    = 32;
  localparam int CFU_TAG_W     = 3;

  typedef struct packed {
    logic [CFU_FUNC_ID_W-1:0] function_id;
    logic [CFU_DATA_W-1:0]    data0;
    logic [CFU_DATA_W-1:0]    data1;
  } cfu_req_t;

  typedef struct packed {
    logic [CFU_DATA_W-1:0] data;
    logic                  status;
  } cfu_resp_t;

  // A limit of 0 means "no counter"; return a minimum width of 1 bit so
  // any declaration sized by this function stays legal.
  function automatic int timeout_cnt_w(input int limit);
    if (limit <= 0) return 1;
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/cfu_tag_fifo.sv
// Synchronous tag FIFO holding the writeback tags of requests that were
// issued but not yet answered by the CFU.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data this cycle (never asserted when full)
//   push_data  : tag to store
//   pop        : drop the head entry this cycle (never asserted when empty)
//   head       : oldest stored tag
//   full/empty : occupancy flags
module cfu_tag_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Storage needs no reset: count gates every read that matters.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/cfu_req_initiator.sv
// CPU-side initiator of the CFU request/response protocol.
// Accepts custom-instruction issues, forwards them to the CFU through a
// one-entry request register, matches the in-order responses with the issue
// tags kept in a tag FIFO and presents results on a writeback port.
//   issue_*     : execute-stage issue port (valid/ready, func id, rs1, rs2, tag)
//   cfu_req_*   : request to the CFU (valid/ready, function id, data0, data1)
//   cfu_resp_*  : response from the CFU (valid/ready, data, status)
//   wb_*        : writeback of results (valid/ready, tag, data, err)
//   timeout_err : sticky flag, head request waited TIMEOUT_CYCLES for a response
//
// Handshakes: every *_valid/*_ready pair transfers exactly on a rising edge
// where both are high. A source never drops valid or changes its payload
// while valid is high and ready is low; ready may depend combinationally on
// valid and on state, valid never depends on ready of the same interface.
module cfu_req_initiator
  import cfu_pkg::*;
#(
  parameter int FUNC_ID_W       = CFU_FUNC_ID_W,
  parameter int DATA_W          = CFU_DATA_W,
  parameter int TAG_W           = CFU_TAG_W,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [FUNC_ID_W-1:0] issue_func_id,
  input  logic [DATA_W-1:0]    issue_rs1,
  input  logic [DATA_W-1:0]    issue_rs2,
  input  logic [TAG_W-1:0]     issue_tag,
  output logic                 cfu_req_valid,
  input  logic                 cfu_req_ready,
  output logic [FUNC_ID_W-1:0] cfu_req_function_id,
  output logic [DATA_W-1:0]    cfu_req_data0,
  output logic [DATA_W-1:0]    cfu_req_data1,
  input  logic                 cfu_resp_valid,
  output logic                 cfu_resp_ready,
  input  logic [DATA_W-1:0]    cfu_resp_data,
  input  logic                 cfu_resp_status,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [TAG_W-1:0]     wb_tag,
  output logic [DATA_W-1:0]    wb_data,
  output logic                 wb_err,
  output logic                 timeout_err
);

  localparam int CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);

  logic             issue_fire;
  logic             req_fire;
  logic             resp_fire;
  logic             tag_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [TAG_W-1:0] tag_head;

  // The request register may be reloaded in the same cycle it hands its
  // current beat to the CFU, giving one issue per cycle.
  assign issue_ready = !timeout_err && !fifo_full && (!cfu_req_valid || cfu_req_ready);
  assign issue_fire  = issue_valid && issue_ready;
  assign req_fire    = cfu_req_valid && cfu_req_ready;

  // With no tag outstanding a response can only be a leftover from before a
  // reset; accept it unconditionally so the CFU is never stuck on it.
  assign cfu_resp_ready = !wb_valid || wb_ready || fifo_empty;
  assign resp_fire      = cfu_resp_valid && cfu_resp_ready;
  assign tag_pop        = resp_fire && !fifo_empty;

  // ---------------------------------------------------------------- request
  always_ff @(posedge clk) begin
    if (rst) begin
      cfu_req_valid       <= 1'b0;
      cfu_req_function_id <= '0;
      cfu_req_data0       <= '0;
      cfu_req_data1       <= '0;
    end else if (issue_fire) begin
      cfu_req_valid       <= 1'b1;
      cfu_req_function_id <= issue_func_id;
      cfu_req_data0       <= issue_rs1;
      cfu_req_data1       <= issue_rs2;
    end else if (req_fire) begin
      cfu_req_valid <= 1'b0;
    end
  end

  // ------------------------------------------------------------- tag FIFO
  // Holds one tag per issued-but-unanswered instruction; its fullness is
  // what limits the number of requests in flight.
  cfu_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (issue_fire),
    .push_data (issue_tag),
    .pop       (tag_pop),
    .head      (tag_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // -------------------------------------------------------------- writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_tag   <= '0;
      wb_data  <= '0;
      wb_err   <= 1'b0;
    end else if (tag_pop) begin
      wb_valid <= 1'b1;
      wb_tag   <= tag_head;
      wb_data  <= cfu_resp_data;
      wb_err   <= cfu_resp_status;
    end else if (wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- timeout
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign timeout_err = 1'b0;
    end else begin : g_timeout
      logic [CNT_W-1:0] to_cnt;
      logic [CNT_W-1:0] to_cnt_next;

      // Measures how long the oldest outstanding request has gone without a
      // response; any response restarts the wait for the next head.
      always_comb begin
        to_cnt_next = to_cnt;
        if (resp_fire || fifo_empty) begin
          to_cnt_next = '0;
        end else if (to_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
          to_cnt_next = to_cnt + CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          to_cnt      <= '0;
          timeout_err <= 1'b0;
        end else begin
          to_cnt <= to_cnt_next;
          if (to_cnt_next == CNT_W'(TIMEOUT_CYCLES)) begin
            timeout_err <= 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_cfu_req_initiator.sv
// Self-checking bench for cfu_req_initiator (TIMEOUT_CYCLES = 16).
// The bench plays both the execute stage and a simple CFU (add/xor/sub,
// unknown function ids answer with error status). A transaction-level model
// tracks issued requests, outstanding count, the expected writeback stream
// and the timeout rule, and every step compares the DUT against it.
module tb_cfu_req_initiator;
  import cfu_pkg::*;

  localparam int FW   = 10;
  localparam int DW   = 32;
  localparam int TW   = 3;
  localparam int MO   = 4;
  localparam int TO   = 16;
  localparam int WB_W = TW + 1 + DW;

  localparam logic [FW-1:0] FN_ADD = 10'd0;
  localparam logic [FW-1:0] FN_XOR = 10'd1;
  localparam logic [FW-1:0] FN_SUB = 10'd2;
  localparam logic [FW-1:0] FN_ERR = 10'h3FF;

  // ------------------------------------------------------- clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          issue_valid = 1'b0;
  logic          issue_ready;
  logic [FW-1:0] issue_func_id = '0;
  logic [DW-1:0] issue_rs1 = '0;
  logic [DW-1:0] issue_rs2 = '0;
  logic [TW-1:0] issue_tag = '0;
  logic          cfu_req_valid;
  logic          cfu_req_ready = 1'b1;
  logic [FW-1:0] cfu_req_function_id;
  logic [DW-1:0] cfu_req_data0;
  logic [DW-1:0] cfu_req_data1;
  logic          cfu_resp_valid = 1'b0;
  logic          cfu_resp_ready;
  logic [DW-1:0] cfu_resp_data = '0;
  logic          cfu_resp_status = 1'b0;
  logic          wb_valid;
  logic          wb_ready = 1'b1;
  logic [TW-1:0] wb_tag;
  logic [DW-1:0] wb_data;
  logic          wb_err;
  logic          timeout_err;

  cfu_req_initiator #(
    .FUNC_ID_W       (FW),
    .DATA_W          (DW),
    .TAG_W           (TW),
    .MAX_OUTSTANDING (MO),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .issue_valid         (issue_valid),
    .issue_ready         (issue_ready),
    .issue_func_id       (issue_func_id),
    .issue_rs1           (issue_rs1),
    .issue_rs2           (issue_rs2),
    .issue_tag           (issue_tag),
    .cfu_req_valid       (cfu_req_valid),
    .cfu_req_ready       (cfu_req_ready),
    .cfu_req_function_id (cfu_req_function_id),
    .cfu_req_data0       (cfu_req_data0),
    .cfu_req_data1       (cfu_req_data1),
    .cfu_resp_valid      (cfu_resp_valid),
    .cfu_resp_ready      (cfu_resp_ready),
    .cfu_resp_data       (cfu_resp_data),
    .cfu_resp_status     (cfu_resp_status),
    .wb_valid            (wb_valid),
    .wb_ready            (wb_ready),
    .wb_tag              (wb_tag),
    .wb_data             (wb_data),
    .wb_err              (wb_err),
    .timeout_err         (timeout_err)
  );

  // ------------------------------------------------------ scoreboard state
  int vectors     = 0;
  int miscompares = 0;

  cfu_req_t        req_q[$];    // issued, not yet taken by the CFU
  logic [WB_W-1:0] exp_q[$];    // expected writebacks {tag, err, data}, in order
  logic [DW:0]     cfu_pend[$]; // CFU model: answers owed {status, data}
  logic [WB_W-1:0] wb_log[$];   // observed writebacks, for directed order checks
  int              outstanding = 0;
  logic [WB_W-1:0] slot = '0;   // result the DUT should be presenting
  bit              slot_valid = 0;
  int              tcnt = 0;
  bit              to_flag = 0;
  bit              cfu_hold = 0;
  bit              relax = 0;
  bit              last_issue_fire = 0;

  function automatic logic [DW:0] cfu_calc(input logic [FW-1:0] f,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    case (f)
      FN_ADD:  return {1'b0, a + b};
      FN_XOR:  return {1'b0, a ^ b};
      FN_SUB:  return {1'b0, a - b};
      default: return {1'b1, a};
    endcase
  endfunction

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // ------------------------------------------------------------ driver tasks
  // One clock: drive CFU response, compare against the model, cross the
  // edge, then advance the model by the handshakes that occurred.
  task automatic step();
    bit              i_f, r_f, rs_f, w_f, exp_ir, exp_rr;
    logic [WB_W-1:0] obs_wb;
    cfu_req_t        r;
    cfu_resp_valid = !cfu_hold && (cfu_pend.size() > 0);
    if (cfu_pend.size() > 0) begin
      cfu_resp_data   = cfu_pend[0][DW-1:0];
      cfu_resp_status = cfu_pend[0][DW];
    end else begin
      cfu_resp_data   = '0;
      cfu_resp_status = 1'b0;
    end
    #1;
    exp_ir = !to_flag && (outstanding < MO) && (req_q.size() == 0 || cfu_req_ready);
    exp_rr = !slot_valid || wb_ready || (outstanding == 0);
    obs_wb = {wb_tag, wb_err, wb_data};
    check("issue_ready", 128'(issue_ready), 128'(exp_ir));
    check("req_valid", 128'(cfu_req_valid), 128'(req_q.size() != 0));
    if (req_q.size() != 0)
      check("req_fields", 128'({cfu_req_function_id, cfu_req_data0, cfu_req_data1}), 128'(req_q[0]));
    check("resp_ready", 128'(cfu_resp_ready), 128'(exp_rr));
    check("wb_valid", 128'(wb_valid), 128'(slot_valid));
    if (slot_valid) check("wb_fields", 128'(obs_wb), 128'(slot));
    check("timeout_err", 128'(timeout_err), 128'(to_flag));
    i_f  = issue_valid && issue_ready;
    r_f  = cfu_req_valid && cfu_req_ready;
    rs_f = cfu_resp_valid && cfu_resp_ready;
    w_f  = wb_valid && wb_ready;
    r.function_id = cfu_req_function_id;
    r.data0       = cfu_req_data0;
    r.data1       = cfu_req_data1;
    @(posedge clk);
    if (rs_f || outstanding == 0) tcnt = 0;
    else tcnt++;
    if (tcnt >= TO) to_flag = 1;
    if (w_f) begin
      slot_valid = 0;
      wb_log.push_back(obs_wb);
    end
    if (rs_f) begin
      void'(cfu_pend.pop_front());
      if (outstanding > 0) begin
        if (exp_q.size() > 0) slot = exp_q.pop_front();
        slot_valid = 1;
        outstanding--;
      end
    end
    if (r_f) begin
      cfu_pend.push_back(cfu_calc(r.function_id, r.data0, r.data1));
      void'(req_q.pop_front());
    end
    if (i_f) begin
      r.function_id = issue_func_id;
      r.data0       = issue_rs1;
      r.data1       = issue_rs2;
      req_q.push_back(r);
      exp_q.push_back({issue_tag, cfu_calc(issue_func_id, issue_rs1, issue_rs2)});
      outstanding++;
    end
    last_issue_fire = i_f;
    @(negedge clk);
  endtask

  task automatic issue_one(input logic [FW-1:0] f, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [TW-1:0] t);
    int n = 0;
    issue_valid   = 1'b1;
    issue_func_id = f;
    issue_rs1     = a;
    issue_rs2     = b;
    issue_tag     = t;
    do begin
      if (relax && n >= 3) begin
        cfu_req_ready = 1'b1;
        wb_ready      = 1'b1;
        cfu_hold      = 0;
      end
      step();
      n++;
    end while (!last_issue_fire && n < 40);
    check("issue_accept", 128'(last_issue_fire), 128'(1));
    issue_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    issue_valid    = 1'b0;
    cfu_resp_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req_q.delete();
    exp_q.delete();
    outstanding = 0;
    slot_valid  = 0;
    tcnt        = 0;
    to_flag     = 0;
    #1;
    check("rst_req_valid", 128'(cfu_req_valid), 128'(0));
    check("rst_req_data", 128'({cfu_req_function_id, cfu_req_data0, cfu_req_data1}), 128'(0));
    check("rst_wb_valid", 128'(wb_valid), 128'(0));
    check("rst_wb_out", 128'({wb_tag, wb_err, wb_data}), 128'(0));
    check("rst_timeout", 128'(timeout_err), 128'(0));
    check("rst_resp_ready", 128'(cfu_resp_ready), 128'(1));
  endtask

  task automatic idle_good(input int n);
    cfu_req_ready = 1'b1;
    wb_ready      = 1'b1;
    cfu_hold      = 0;
    repeat (n) step();
  endtask

  // ---------------------------------------------------------- directed run
  initial begin
    logic [FW-1:0] f;
    do_reset();
    idle_good(3);

    // Single op: 5 + 7 on tag 3
    wb_log.delete();
    issue_one(FN_ADD, 32'h5, 32'h7, 3'd3);
    check("single_req_latency", 128'(cfu_req_valid), 128'(1));
    idle_good(6);
    check("single_wb", 128'(wb_log.size() > 0 ? wb_log[0] : '0), 128'({3'd3, 1'b0, 32'hC}));

    // Request backpressure: CFU not ready for 5 cycles
    cfu_req_ready = 1'b0;
    issue_one(FN_XOR, 32'hA5A5_0000, 32'h0000_5A5A, 3'd1);
    issue_valid = 1'b1; issue_func_id = FN_SUB; issue_rs1 = 32'd100; issue_rs2 = 32'd1; issue_tag = 3'd2;
    repeat (5) begin
      step();
      check("bp_no_issue", 128'(last_issue_fire), 128'(0));
    end
    cfu_req_ready = 1'b1;
    issue_one(FN_SUB, 32'd100, 32'd1, 3'd2);
    idle_good(6);

    // Fill: CFU withholds responses, 5th issue must wait
    wb_log.delete();
    cfu_hold = 1;
    for (int i = 0; i < 4; i++) issue_one(FN_ADD, 32'(i * 16), 32'd1, TW'(i));
    issue_valid = 1'b1; issue_func_id = FN_ADD; issue_rs1 = 32'd64; issue_rs2 = 32'd1; issue_tag = 3'd4;
    repeat (3) begin
      step();
      check("full_no_issue", 128'(last_issue_fire), 128'(0));
    end
    cfu_hold = 0;
    issue_one(FN_ADD, 32'd64, 32'd1, 3'd4);
    idle_good(8);
    for (int i = 0; i < 4; i++)
      check("fill_order", 128'(wb_log.size() > i ? wb_log[i][WB_W-1 -: TW] : 3'd7), 128'(i));

    // Writeback backpressure with two results pending
    wb_log.delete();
    wb_ready = 1'b0;
    issue_one(FN_ADD, 32'd10, 32'd20, 3'd1);
    issue_one(FN_ADD, 32'd30, 32'd40, 3'd2);
    step();
    repeat (3) begin
      step();
      check("wb_bp_resp_ready", 128'(cfu_resp_ready), 128'(0));
    end
    idle_good(6);
    check("wb_bp_first", 128'(wb_log.size() > 0 ? wb_log[0] : '0), 128'({3'd1, 1'b0, 32'd30}));
    check("wb_bp_second", 128'(wb_log.size() > 1 ? wb_log[1] : '0), 128'({3'd2, 1'b0, 32'd70}));

    // Error status only on tag 6
    wb_log.delete();
    issue_one(FN_ADD, 32'd1, 32'd2, 3'd5);
    issue_one(FN_ERR, 32'hDEAD, 32'd0, 3'd6);
    issue_one(FN_XOR, 32'hF0, 32'h0F, 3'd7);
    idle_good(6);
    for (int i = 0; i < 3; i++)
      check("err_bit", 128'(wb_log.size() > i ? wb_log[i][DW] : 1'bx), 128'(i == 1));

    // Randomized traffic
    relax = 1;
    for (int i = 0; i < 300; i++) begin
      cfu_req_ready = ($urandom_range(0, 3) != 0);
      wb_ready      = ($urandom_range(0, 3) != 0);
      cfu_hold      = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 4))
        0:       f = FN_XOR;
        1:       f = FN_SUB;
        2:       f = FN_ERR;
        default: f = FN_ADD;
      endcase
      issue_one(f, $urandom, $urandom, TW'($urandom_range(0, 7)));
    end
    relax = 0;
    idle_good(20);
    check("drain_empty", 128'(exp_q.size()), 128'(0));

    // Timeout: one request never answered
    cfu_hold = 1;
    issue_one(FN_ADD, 32'd3, 32'd4, 3'd0);
    repeat (TO - 1) step();
    check("timeout_before", 128'(timeout_err), 128'(0));
    step();
    check("timeout_at", 128'(timeout_err), 128'(1));
    check("timeout_block", 128'(issue_ready), 128'(0));
    cfu_hold = 0;
    wb_log.delete();
    repeat (4) step();
    check("timeout_drain", 128'(wb_log.size() > 0 ? wb_log[0] : '0), 128'({3'd0, 1'b0, 32'd7}));
    check("timeout_sticky", 128'(timeout_err), 128'(1));
    do_reset();
    idle_good(2);

    // Reset with responses still owed: late responses are discarded
    cfu_hold = 1;
    issue_one(FN_ADD, 32'd1, 32'd1, 3'd1);
    issue_one(FN_ADD, 32'd2, 32'd2, 3'd2);
    step();
    do_reset();
    idle_good(6);
    check("stale_drained", 128'(cfu_pend.size()), 128'(0));
    wb_log.delete();
    issue_one(FN_ADD, 32'h5, 32'h7, 3'd3);
    idle_good(6);
    check("post_rst_wb", 128'(wb_log.size() == 1 ? wb_log[0] : '0), 128'({3'd3, 1'b0, 32'hC}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
